// File: rtl/dcache_port_arb.sv
// Single-port data-cache access controller: arbitrates MSHR refill, store and
// load requests onto one cache port, one command in flight at a time.
module dcache_port_arb #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill_req_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  output logic              fill_ack_o,
  input  logic              st_req_i,
  input  logic [ADDR_W-1:0] st_addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic              st_urgent_i,
  output logic              st_ack_o,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output logic              ld_ack_o,
  output logic [DATA_W-1:0] ld_data_o,
  input  logic              flush_i,
  output logic              cache_en_o,
  output logic              cache_we_o,
  output logic [ADDR_W-1:0] cache_addr_o,
  output logic [DATA_W-1:0] cache_wdata_o,
  input  logic              cache_done_i,
  input  logic [DATA_W-1:0] cache_rdata_i
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_SAT = SC_W'(STARVE_MAX);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [1:0] SRC_FILL = 2'd0;
  localparam logic [1:0] SRC_ST   = 2'd1;
  localparam logic [1:0] SRC_LD   = 2'd2;

  logic [0:0]        state_q, state_d;
  logic [1:0]        src_q, src_d;
  logic              kill_q, kill_d;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic done_s;
  logic arb_s;
  logic gnt_fill_s;
  logic gnt_st_s;
  logic gnt_ld_s;
  logic win_s;
  logic st_starved_s;

  assign done_s       = (state_q == S_BUSY) & cache_done_i;
  assign arb_s        = (state_q == S_IDLE) | done_s;
  assign st_starved_s = st_urgent_i | (starve_q == STARVE_SAT);

  // Fixed-priority winner selection; a load can never win while flush is high
  always_comb begin
    gnt_fill_s = 1'b0;
    gnt_st_s   = 1'b0;
    gnt_ld_s   = 1'b0;
    if (arb_s) begin
      if (fill_req_i) begin
        gnt_fill_s = 1'b1;
      end else if (st_req_i && st_starved_s) begin
        gnt_st_s = 1'b1;
      end else if (ld_req_i && !flush_i) begin
        gnt_ld_s = 1'b1;
      end else if (st_req_i) begin
        gnt_st_s = 1'b1;
      end else begin
        gnt_fill_s = 1'b0;
      end
    end else begin
      gnt_fill_s = 1'b0;
    end
  end

  assign win_s = gnt_fill_s | gnt_st_s | gnt_ld_s;

  // Command register next-state: capture the winner's address/data/direction
  always_comb begin
    src_d   = src_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    en_d    = win_s;
    if (gnt_fill_s) begin
      src_d   = SRC_FILL;
      we_d    = 1'b1;
      addr_d  = fill_addr_i;
      wdata_d = fill_data_i;
    end else if (gnt_st_s) begin
      src_d   = SRC_ST;
      we_d    = 1'b1;
      addr_d  = st_addr_i;
      wdata_d = st_data_i;
    end else if (gnt_ld_s) begin
      src_d   = SRC_LD;
      we_d    = 1'b0;
      addr_d  = ld_addr_i;
      wdata_d = {DATA_W{1'b0}};
    end else begin
      en_d = 1'b0;
    end
  end

  // Control next-state: busy/idle, load kill flag and store starvation count
  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    starve_d = starve_q;

    if (win_s) begin
      state_d = S_BUSY;
    end else if (done_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_q;
    end

    // completion retires the kill; otherwise a flush poisons an in-flight load
    if (done_s) begin
      kill_d = 1'b0;
    end else if ((state_q == S_BUSY) && (src_q == SRC_LD) && flush_i) begin
      kill_d = 1'b1;
    end else begin
      kill_d = kill_q;
    end

    if (!st_req_i || gnt_st_s) begin
      starve_d = {SC_W{1'b0}};
    end else if (gnt_ld_s) begin
      starve_d = (starve_q == STARVE_SAT) ? starve_q : starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State and command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      src_q    <= SRC_FILL;
      kill_q   <= 1'b0;
      starve_q <= {SC_W{1'b0}};
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      kill_q   <= kill_d;
      starve_q <= starve_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Completion acks follow cache_done_i in the same cycle
  always_comb begin
    fill_ack_o = 1'b0;
    st_ack_o   = 1'b0;
    ld_ack_o   = 1'b0;
    if (done_s) begin
      case (src_q)
        SRC_FILL: fill_ack_o = 1'b1;
        SRC_ST:   st_ack_o   = 1'b1;
        SRC_LD:   ld_ack_o   = !kill_q && !flush_i;
        default:  fill_ack_o = 1'b0;
      endcase
    end else begin
      fill_ack_o = 1'b0;
    end
  end

  assign cache_en_o    = en_q;
  assign cache_we_o    = we_q;
  assign cache_addr_o  = addr_q;
  assign cache_wdata_o = wdata_q;
  assign ld_data_o     = cache_rdata_i;

endmodule

// File: tb/tb_dcache_port_arb.sv
// Randomized scoreboard bench for dcache_port_arb: a rule-level model predicts
// commands and acks, a separate monitor matches what the DUT presents.
module tb_dcache_port_arb;

  localparam int AW   = 64;
  localparam int DW   = 64;
  localparam int SMAX = 4;

  localparam int SRC_NONE = 0;
  localparam int SRC_F    = 1;
  localparam int SRC_S    = 2;
  localparam int SRC_L    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fill_req_i = 1'b0, st_req_i = 1'b0, ld_req_i = 1'b0;
  logic [AW-1:0] fill_addr_i = '0, st_addr_i = '0, ld_addr_i = '0;
  logic [DW-1:0] fill_data_i = '0, st_data_i = '0;
  logic          st_urgent_i = 1'b0, flush_i = 1'b0, cache_done_i = 1'b0;
  logic [DW-1:0] cache_rdata_i = '0;
  logic          fill_ack_o, st_ack_o, ld_ack_o;
  logic [DW-1:0] ld_data_o;
  logic          cache_en_o, cache_we_o;
  logic [AW-1:0] cache_addr_o;
  logic [DW-1:0] cache_wdata_o;

  dcache_port_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_req_i(fill_req_i), .fill_addr_i(fill_addr_i), .fill_data_i(fill_data_i), .fill_ack_o(fill_ack_o),
    .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_urgent_i(st_urgent_i), .st_ack_o(st_ack_o),
    .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_ack_o(ld_ack_o), .ld_data_o(ld_data_o),
    .flush_i(flush_i),
    .cache_en_o(cache_en_o), .cache_we_o(cache_we_o), .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
    .cache_done_i(cache_done_i), .cache_rdata_i(cache_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    int unsigned   cyc;
    int            src;
    logic [DW-1:0] data;
  } ack_t;

  cmd_t exp_cmd_q[$];
  ack_t exp_ack_q[$];

  int unsigned cyc = 0;
  int compared = 0;
  int mismatched = 0;
  bit checking = 1'b0;
  bit gen_en = 1'b1;

  // reference model: what the port is doing, in spec terms
  bit          m_busy = 1'b0;
  int          m_src = SRC_F;
  bit          m_kill = 1'b0;
  int          m_starve = 0;
  int unsigned m_done_cyc = 0;

  // requester bookkeeping
  bit          f_pend = 1'b0, s_pend = 1'b0, l_pend = 1'b0;
  logic [AW-1:0] f_addr = '0, s_addr = '0, l_addr = '0;
  logic [DW-1:0] f_data = '0, s_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: consume expectations whenever the DUT issues a command or an ack
  always @(negedge clk) begin : mon
    cmd_t c;
    ack_t a;
    logic [2:0] acks;
    logic [2:0] expv;
    if (checking) begin
      while (exp_cmd_q.size() > 0 && exp_cmd_q[0].cyc < cyc) begin
        c = exp_cmd_q.pop_front();
        check("cmd_missing_at", 128'(c.cyc), 128'(cyc));
      end
      while (exp_ack_q.size() > 0 && exp_ack_q[0].cyc < cyc) begin
        a = exp_ack_q.pop_front();
        check("ack_missing_at", 128'(a.cyc), 128'(cyc));
      end
      if (cache_en_o) begin
        if (exp_cmd_q.size() == 0) begin
          check("cmd_unexpected", 128'(1), 128'(0));
        end else begin
          c = exp_cmd_q.pop_front();
          check("cmd_cycle", 128'(cyc), 128'(c.cyc));
          check("cmd_we", 128'(cache_we_o), 128'(c.we));
          check("cmd_addr", 128'(cache_addr_o), 128'(c.addr));
          check("cmd_wdata", 128'(cache_wdata_o), 128'(c.wdata));
        end
      end
      acks = {fill_ack_o, st_ack_o, ld_ack_o};
      if (acks != 3'b000) begin
        if (exp_ack_q.size() == 0) begin
          check("ack_unexpected", 128'(acks), 128'(0));
        end else begin
          a = exp_ack_q.pop_front();
          expv = (a.src == SRC_F) ? 3'b100 : (a.src == SRC_S) ? 3'b010 : 3'b001;
          check("ack_cycle", 128'(cyc), 128'(a.cyc));
          check("ack_src", 128'(acks), 128'(expv));
          if (a.src == SRC_L) check("ld_data", 128'(ld_data_o), 128'(a.data));
        end
      end
    end
  end

  // One clock of stimulus plus the model's prediction for that clock
  task automatic step();
    bit fr, sr, lr, urg, fl, done, arb;
    int w;
    cmd_t c;
    ack_t a;
    @(posedge clk);
    #1;
    if (gen_en) begin
      if (!f_pend && $urandom_range(0, 9) == 0) begin
        f_pend = 1'b1; f_addr = {$urandom, $urandom}; f_data = {$urandom, $urandom};
      end
      if (!s_pend && $urandom_range(0, 3) == 0) begin
        s_pend = 1'b1; s_addr = {$urandom, $urandom}; s_data = {$urandom, $urandom};
      end
      if (!l_pend && $urandom_range(0, 1) == 0) begin
        l_pend = 1'b1; l_addr = {$urandom, $urandom};
      end
    end
    fr = f_pend; sr = s_pend; lr = l_pend;
    urg  = sr && ($urandom_range(0, 5) == 0);
    fl   = ($urandom_range(0, 9) == 0);
    done = m_busy ? (cyc == m_done_cyc) : ($urandom_range(0, 3) == 0);

    fill_req_i = fr; fill_addr_i = f_addr; fill_data_i = f_data;
    st_req_i = sr; st_addr_i = s_addr; st_data_i = s_data; st_urgent_i = urg;
    ld_req_i = lr; ld_addr_i = l_addr;
    flush_i = fl; cache_done_i = done; cache_rdata_i = {$urandom, $urandom};

    if (m_busy && done) begin
      a.cyc = cyc; a.src = m_src; a.data = cache_rdata_i;
      if (m_src != SRC_L || (!m_kill && !fl)) exp_ack_q.push_back(a);
    end

    arb = !m_busy || done;
    w = SRC_NONE;
    if (arb) begin
      if (fr) w = SRC_F;
      else if (sr && (urg || m_starve == SMAX)) w = SRC_S;
      else if (lr && !fl) w = SRC_L;
      else if (sr) w = SRC_S;
    end
    if (w != SRC_NONE) begin
      c.cyc = cyc + 1;
      c.we = (w != SRC_L);
      c.addr = (w == SRC_F) ? f_addr : (w == SRC_S) ? s_addr : l_addr;
      c.wdata = (w == SRC_F) ? f_data : (w == SRC_S) ? s_data : '0;
      exp_cmd_q.push_back(c);
    end

    if (!sr || w == SRC_S) m_starve = 0;
    else if (w == SRC_L && m_starve < SMAX) m_starve = m_starve + 1;

    if (m_busy && done) m_kill = 1'b0;
    else if (m_busy && m_src == SRC_L && fl) m_kill = 1'b1;

    if (m_busy && done) begin
      if (m_src == SRC_F) f_pend = 1'b0;
      if (m_src == SRC_S) s_pend = 1'b0;
      if (m_src == SRC_L && !m_kill && !fl) l_pend = 1'b0;
    end
    if (fl) l_pend = 1'b0;

    if (w != SRC_NONE) begin
      m_busy = 1'b1; m_src = w; m_kill = 1'b0;
      m_done_cyc = cyc + 2 + $urandom_range(0, 2);
    end else if (m_busy && done) begin
      m_busy = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_cmd_q.delete();
    exp_ack_q.delete();
    m_busy = 1'b0; m_src = SRC_F; m_kill = 1'b0; m_starve = 0;
    f_pend = 1'b0; s_pend = 1'b0; l_pend = 1'b0;
    fill_req_i = 1'b0; st_req_i = 1'b0; ld_req_i = 1'b0;
    st_urgent_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_en"}, 128'(cache_en_o), 128'(0));
    check({tag, "_we"}, 128'(cache_we_o), 128'(0));
    check({tag, "_addr"}, 128'(cache_addr_o), 128'(0));
    check({tag, "_wdata"}, 128'(cache_wdata_o), 128'(0));
    check({tag, "_acks"}, 128'({fill_ack_o, st_ack_o, ld_ack_o}), 128'(0));
  endtask

  // Reset while a command is outstanding: abandoned, and a late done gives no ack
  task automatic reset_mid_op();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    cache_done_i = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cache_done_i = 1'b1;
    #1;
    check_outputs_zero("postrst");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    fill_req_i = 1'b1; st_req_i = 1'b1; ld_req_i = 1'b1;
    cache_done_i = 1'b1; cache_rdata_i = 64'hDEAD_BEEF_0123_4567;
    #1;
    check_outputs_zero("rst");
    check("rst_ld_data", 128'(ld_data_o), 128'(64'hDEAD_BEEF_0123_4567));
    @(posedge clk);
    #1;
    check_outputs_zero("rst_held");
    model_reset();
    cache_done_i = 1'b0;
    rst_n = 1'b1;
    checking = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        for (int k = 0; k < 50 && !m_busy; k++) step();
        reset_mid_op();
      end
    end
    gen_en = 1'b0;
    for (int i = 0; i < 60; i++) step();

    @(posedge clk);
    #1;
    fill_req_i = 1'b0; st_req_i = 1'b0; ld_req_i = 1'b0;
    cache_done_i = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    check("cmd_queue_drained", 128'(exp_cmd_q.size()), 128'(0));
    check("ack_queue_drained", 128'(exp_ack_q.size()), 128'(0));
    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dcache_port_arb.md
# dcache_port_arb

Single-port data-cache access controller sitting between the load/store queue and the data cache. It arbitrates three requesters for the one cache port: MSHR refill writes, retiring stores, and loads. Only one cache operation is in flight at a time. Each requester sees a req/ack handshake, and a branch-recovery flush can cancel an in-flight load.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, data width
- STARVE_MAX, 4, consecutive lost arbitration cycles after which a pending store outranks loads (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- fill_req_i  in  1  MSHR refill write request; held until fill_ack_o
- fill_addr_i  in  ADDR_W  refill address
- fill_data_i  in  DATA_W  refill data
- fill_ack_o  out  1  refill write completed
- st_req_i  in  1  retiring-store write request; held until st_ack_o
- st_addr_i  in  ADDR_W  store address
- st_data_i  in  DATA_W  store data
- st_urgent_i  in  1  store queue full; store outranks loads
- st_ack_o  out  1  store write completed
- ld_req_i  in  1  load read request; held until ld_ack_o or dropped on flush
- ld_addr_i  in  ADDR_W  load address
- ld_ack_o  out  1  load data valid on ld_data_o
- ld_data_o  out  DATA_W  load data; equals cache_rdata_i
- flush_i  in  1  branch recovery; kills any load grant or in-flight load
- cache_en_o  out  1  one-cycle command strobe
- cache_we_o  out  1  1 = write (fill/store), 0 = read (load)
- cache_addr_o  out  ADDR_W  command address
- cache_wdata_o  out  DATA_W  write data
- cache_done_i  in  1  cache completed the outstanding command
- cache_rdata_i  in  DATA_W  read data, valid with cache_done_i

## Operation
- States: IDLE (no command outstanding) and BUSY (one command outstanding). Registered source tag src_r ∈ {FILL, ST, LD}. Registered kill_r flag.
- Arbitration is evaluated in IDLE, and in BUSY during the cycle cache_done_i=1.
- Priority order:
  - fill_req_i first.
  - Then store, if st_req_i and (st_urgent_i or starve_cnt==STARVE_MAX).
  - Then load, if ld_req_i and !flush_i.
  - Then store.
- A load is never granted in a cycle where flush_i=1.
- On a winner: the command registers (addr, wdata, we, src_r) load, state becomes BUSY, and cache_en_o=1 for exactly the next cycle.
- starve_cnt is $clog2(STARVE_MAX+1) bits:
  - increments, saturating at STARVE_MAX, in each arbitration cycle where st_req_i=1 and a load wins;
  - clears when a store is granted or when st_req_i=0.
  - Fill wins leave it unchanged.
- Completion (BUSY, cache_done_i=1):
  - Pulse the ack matching src_r for that cycle.
  - ld_ack_o is suppressed if kill_r=1, or if flush_i=1 in that same cycle.
  - Then go IDLE, or stay BUSY if a new winner was chosen that cycle.
- Flush:
  - flush_i=1 while BUSY with src_r=LD sets kill_r. kill_r clears on completion.
  - Fill and store operations are unaffected by flush.
- cache_wdata_o is 0 for load commands.
- ld_data_o is a pass-through of cache_rdata_i.
- Requests deasserted before being granted are simply not served; nothing latches them.

## Timing
- Reset (async assert; state held while rst_n=0):
  - state=IDLE, src_r=FILL, kill_r=0, starve_cnt=0.
  - All outputs 0: cache_en_o, cache_we_o, cache_addr_o, cache_wdata_o, and all acks.
  - ld_data_o follows cache_rdata_i.
- Reset asserted mid-operation abandons the outstanding command. No ack is issued.
- Grant to command: request sampled in cycle N, cache_en_o high in N+1.
- Earliest cache_done_i is N+2. The ack is combinational with cache_done_i.
- Back-to-back: a new cache_en_o is possible in the cycle after cache_done_i, so one op per 2 cycles minimum.
- cache_done_i in IDLE is ignored.

## Test plan
- Reset and idle: with rst_n low, all outputs are 0. Release; single load to addr 0x100, done at +2 with rdata 0xDEAD. Expect cache_en_o/we=0/addr=0x100 at N+1, then ld_ack_o=1 and ld_data_o=0xDEAD at N+2.
- Simultaneous fill, store and load in cycle N: fill is served first, then the load (store not starved), then the store. Check the three ack orders and the cache_we_o values 1,0,1.
- Starvation, STARVE_MAX=4: continuous ld_req_i and st_req_i, each done at +2. Loads win 4 times, the 5th grant goes to the store, and starve_cnt returns to 0.
- st_urgent_i=1 with ld_req_i=1: the store is granted first.
- Flush on an in-flight load: flush_i pulses at N+1. cache_done_i comes at N+3 with no ld_ack_o, state goes IDLE, and a held store is granted next.
- Flush in an arbitration cycle with only ld_req_i: no cache_en_o the following cycle. Assert rst_n low while BUSY: outputs are 0 immediately, and the later cache_done_i produces no ack.
